// File: rtl/ubuff_x8.sv
// ubuff_x8: 8-lane word-compacting buffer; valid lanes are packed (lane 7 first) into full 8-word vectors.
// Optional macro UBUFF_OCC_EN adds occ_out, the registered fill count.
module ubuff_x8 #(
   parameter int DATA_W = 64,
   parameter int LANES  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    last_input_in,
   input  logic [LANES*DATA_W-1:0] word_in,
   input  logic [LANES-1:0]        word_in_valid,
   output logic [LANES*DATA_W-1:0] word_out,
   output logic [LANES-1:0]        valid_out
`ifdef UBUFF_OCC_EN
   ,
   output logic [3:0]              occ_out
`endif
);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t                  state_q, state_d;
   logic [DATA_W-1:0]       store_q [LANES-1];
   logic [DATA_W-1:0]       store_d [LANES-1];
   logic [2:0]              fill_q, fill_d;
   logic [DATA_W-1:0]       comp    [LANES];
   logic [DATA_W-1:0]       merged  [2*LANES-1];
   logic [LANES*DATA_W-1:0] word_d;
   logic [LANES-1:0]        valid_d;
   logic [3:0]              n_in;
   logic [3:0]              total;
   logic [3:0]              emit_cnt;
   logic [3:0]              idx;
   logic                    last_eff;

   // Compact the valid input lanes, lane 7 first; a pending flush cycle ignores the inputs.
   always_comb begin
      n_in = 4'd0;
      for (int k = 0; k < LANES; k++) comp[k] = '0;
      if (state_q == ST_RUN) begin
         for (int l = LANES-1; l >= 0; l--) begin
            if (word_in_valid[l]) begin
               comp[n_in[2:0]] = word_in[l*DATA_W +: DATA_W];
               n_in = n_in + 4'd1;
            end
         end
      end
   end

   // Oldest-first view of buffered words followed by the newly compacted ones.
   always_comb begin
      idx = 4'd0;
      for (int i = 0; i < 2*LANES-1; i++) merged[i] = '0;
      for (int i = 0; i < LANES-1; i++) begin
         if (3'(i) < fill_q) merged[i] = store_q[i];
      end
      for (int k = 0; k < LANES; k++) begin
         if (4'(k) < n_in) begin
            idx = {1'b0, fill_q} + 4'(k);
            merged[idx] = comp[k];
         end
      end
   end

   always_comb begin
      total    = {1'b0, fill_q} + n_in;
      last_eff = last_input_in || (state_q == ST_FLUSH);
      state_d  = ST_RUN;
      emit_cnt = 4'd0;
      fill_d   = fill_q;
      for (int k = 0; k < LANES-1; k++) store_d[k] = store_q[k];

      if (last_eff && total <= 4'd8) begin
         emit_cnt = total;
         fill_d   = 3'd0;
         for (int k = 0; k < LANES-1; k++) store_d[k] = '0;
      end else if (total >= 4'd8) begin
         // An overflowing last beat leaves a remainder that drains next cycle.
         emit_cnt = 4'd8;
         fill_d   = 3'(total - 4'd8);
         for (int k = 0; k < LANES-1; k++) store_d[k] = merged[k+LANES];
         state_d  = last_input_in ? ST_FLUSH : ST_RUN;
      end else begin
         fill_d = total[2:0];
         for (int k = 0; k < LANES-1; k++) store_d[k] = merged[k];
      end

      word_d  = '0;
      valid_d = '0;
      for (int j = 0; j < LANES; j++) begin
         if (4'(j) < emit_cnt) begin
            word_d[(LANES-1-j)*DATA_W +: DATA_W] = merged[j];
            valid_d[LANES-1-j] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         fill_q    <= 3'd0;
         word_out  <= '0;
         valid_out <= '0;
         for (int k = 0; k < LANES-1; k++) store_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         word_out  <= word_d;
         valid_out <= valid_d;
         for (int k = 0; k < LANES-1; k++) store_q[k] <= store_d[k];
      end
   end

`ifdef UBUFF_OCC_EN
   assign occ_out = {1'b0, fill_q};
`endif

endmodule

// File: tb/tb_ubuff_x8.sv
// Self-checking bench for ubuff_x8: a word-queue reference model feeds a scoreboard,
// and the table entries also carry hand-derived valid_out values.
module tb_ubuff_x8;

   logic         clk = 1'b0;
   logic         rst;
   logic         last_input_in;
   logic [511:0] word_in;
   logic [7:0]   word_in_valid;
   logic [511:0] word_out;
   logic [7:0]   valid_out;
`ifdef UBUFF_OCC_EN
   logic [3:0]   occ_out;
`endif

   ubuff_x8 dut (
      .clk           (clk),
      .rst           (rst),
      .last_input_in (last_input_in),
      .word_in       (word_in),
      .word_in_valid (word_in_valid),
      .word_out      (word_out),
      .valid_out     (valid_out)
`ifdef UBUFF_OCC_EN
      ,
      .occ_out       (occ_out)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [511:0] word;
      logic [7:0]   valid;
      logic         useHand;
      logic [7:0]   handValid;
   } exp_t;

   typedef struct {
      logic [7:0]   mask;
      logic         last;
      logic [511:0] data;
      logic [7:0]   expValid;
   } vec_t;

   exp_t        scoreboard[$];
   vec_t        vecs[$];
   logic [63:0] pend[$];
   logic        flushPend = 1'b0;
   int          testsRun = 0;
   int          testsFailed = 0;

   function automatic logic [511:0] pat(input int seed);
      logic [511:0] r;
      for (int l = 0; l < 8; l++) r[l*64 +: 64] = {32'(seed), 32'(l + 1)};
      return r;
   endfunction

   // Reference: a plain FIFO of words; emit when 8 are queued or a last beat flushes.
   task automatic modelStep(input logic [7:0] mask, input logic last, input logic [511:0] data,
                            output logic [511:0] ew, output logic [7:0] ev);
      int c;
      ew = '0;
      ev = '0;
      if (flushPend) begin
         c = pend.size();
         for (int j = 0; j < c; j++) begin
            ew[(7-j)*64 +: 64] = pend.pop_front();
            ev[7-j] = 1'b1;
         end
         flushPend = 1'b0;
         return;
      end
      for (int l = 7; l >= 0; l--) if (mask[l]) pend.push_back(data[l*64 +: 64]);
      if (pend.size() >= 8 || (last && pend.size() > 0)) begin
         c = (pend.size() >= 8) ? 8 : pend.size();
         for (int j = 0; j < c; j++) begin
            ew[(7-j)*64 +: 64] = pend.pop_front();
            ev[7-j] = 1'b1;
         end
      end
      if (last && pend.size() > 0) flushPend = 1'b1;
   endtask

   task automatic checkOutput();
      exp_t e;
      if (scoreboard.size() == 0) return;
      e = scoreboard.pop_front();
      testsRun++;
      if (valid_out !== e.valid) begin
         testsFailed++;
         $display("[TB] FAIL valid_out vs model: got %02h expected %02h", valid_out, e.valid);
      end
      testsRun++;
      if (word_out !== e.word) begin
         testsFailed++;
         $display("[TB] FAIL word_out vs model: got %0h expected %0h", word_out, e.word);
      end
      if (e.useHand) begin
         testsRun++;
         if (valid_out !== e.handValid) begin
            testsFailed++;
            $display("[TB] FAIL valid_out vs table: got %02h expected %02h", valid_out, e.handValid);
         end
      end
   endtask

   task automatic applyStimulus(input logic [7:0] mask, input logic last, input logic [511:0] data,
                                input logic useHand, input logic [7:0] handValid);
      exp_t e;
      @(negedge clk);
      checkOutput();
      word_in_valid = mask;
      last_input_in = last;
      word_in       = data;
      modelStep(mask, last, data, e.word, e.valid);
      e.useHand   = useHand;
      e.handValid = handValid;
      scoreboard.push_back(e);
   endtask

   task automatic checkReset(input string tag);
      testsRun++;
      if (valid_out !== 8'h00) begin
         testsFailed++;
         $display("[TB] FAIL %s valid_out: got %02h expected 00", tag, valid_out);
      end
      testsRun++;
      if (word_out !== '0) begin
         testsFailed++;
         $display("[TB] FAIL %s word_out: got %0h expected 0", tag, word_out);
      end
   endtask

   task automatic addVec(input logic [7:0] mask, input logic last, input logic [511:0] data,
                         input logic [7:0] expValid);
      vec_t v;
      v.mask = mask; v.last = last; v.data = data; v.expValid = expValid;
      vecs.push_back(v);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [511:0] d;
      rst           = 1'b0;
      last_input_in = 1'b0;
      word_in       = '0;
      word_in_valid = '0;

      repeat (3) begin
         @(negedge clk);
         checkReset("reset");
      end
      rst = 1'b1;
      applyStimulus(8'h00, 1'b0, '0, 1'b1, 8'h00);
      applyStimulus(8'h00, 1'b0, '0, 1'b1, 8'h00);

      // Partial flush stream with the documented word values.
      d = pat(100);
      d[7*64 +: 64] = 64'h0000000100000002;
      d[6*64 +: 64] = 64'h0000000300000004;
      d[5*64 +: 64] = 64'h0000000500000006;
      d[4*64 +: 64] = 64'h0000000700000008;
      addVec(8'hF0, 1'b0, d, 8'h00);
      d = pat(101);
      d[7*64 +: 64] = 64'h0000000A0000000B;
      addVec(8'h80, 1'b0, d, 8'h00);
      d = pat(102);
      d[7*64 +: 64] = 64'h0000000100000002;
      addVec(8'h80, 1'b1, d, 8'hFC);
      addVec(8'h00, 1'b0, pat(103), 8'h00);
      // Full vector from two half beats.
      addVec(8'hF0, 1'b0, pat(1), 8'h00);
      addVec(8'hF0, 1'b0, pat(2), 8'hFF);
      addVec(8'h00, 1'b0, pat(3), 8'h00);
      // Overflow without last: 5 buffered + 8 new.
      addVec(8'hF8, 1'b0, pat(4), 8'h00);
      addVec(8'hFF, 1'b0, pat(5), 8'hFF);
      addVec(8'h00, 1'b0, pat(6), 8'h00);
      addVec(8'h00, 1'b1, pat(7), 8'hF8);
      addVec(8'h00, 1'b0, pat(8), 8'h00);
      // Overflowing last beat.
      addVec(8'hE0, 1'b0, pat(9), 8'h00);
      addVec(8'hFF, 1'b1, pat(10), 8'hFF);
      addVec(8'h00, 1'b0, pat(11), 8'hE0);
      addVec(8'h00, 1'b0, pat(12), 8'h00);
      // Inputs during the flush cycle are dropped.
      addVec(8'hE0, 1'b0, pat(13), 8'h00);
      addVec(8'hFF, 1'b1, pat(14), 8'hFF);
      addVec(8'hFF, 1'b0, pat(15), 8'hE0);
      addVec(8'h00, 1'b1, pat(16), 8'h00);
      // Sparse masks then flush.
      addVec(8'h01, 1'b0, pat(17), 8'h00);
      addVec(8'h81, 1'b0, pat(18), 8'h00);
      addVec(8'h24, 1'b0, pat(19), 8'h00);
      addVec(8'h00, 1'b1, pat(20), 8'hF8);
      addVec(8'h00, 1'b0, pat(21), 8'h00);
      // Empty last, exact-8 last, and 4+4 last.
      addVec(8'h00, 1'b1, pat(22), 8'h00);
      addVec(8'hFF, 1'b1, pat(23), 8'hFF);
      addVec(8'h00, 1'b0, pat(24), 8'h00);
      addVec(8'hF0, 1'b0, pat(25), 8'h00);
      addVec(8'hF0, 1'b1, pat(26), 8'hFF);
      addVec(8'h00, 1'b0, pat(27), 8'h00);

      for (int i = 0; i < vecs.size(); i++)
         applyStimulus(vecs[i].mask, vecs[i].last, vecs[i].data, 1'b1, vecs[i].expValid);

      // Mid-stream reset discards buffered words.
      applyStimulus(8'hF0, 1'b0, pat(40), 1'b1, 8'h00);
      @(negedge clk);
      checkOutput();
      rst           = 1'b0;
      word_in_valid = '0;
      last_input_in = 1'b0;
      pend.delete();
      flushPend = 1'b0;
      scoreboard.delete();
      @(negedge clk);
      checkReset("midreset");
      rst = 1'b1;
      applyStimulus(8'h00, 1'b1, pat(41), 1'b1, 8'h00);
      applyStimulus(8'h00, 1'b0, pat(42), 1'b1, 8'h00);

      // Random stream checked against the model.
      for (int i = 0; i < 200; i++) begin
         for (int l = 0; l < 8; l++) d[l*64 +: 64] = {$urandom, $urandom};
         applyStimulus(8'($urandom), ($urandom_range(0, 9) == 0), d, 1'b0, 8'h00);
      end

      applyStimulus(8'h00, 1'b1, '0, 1'b0, 8'h00);
      applyStimulus(8'h00, 1'b1, '0, 1'b0, 8'h00);
      applyStimulus(8'h00, 1'b0, '0, 1'b1, 8'h00);
      @(negedge clk);
      checkOutput();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ubuff_x8.md
Name: ubuff_x8

Overview:
- 8-lane word-compacting buffer for the edge/update datapath.
- Each cycle it accepts up to eight 64-bit words with a per-lane valid mask and discards the invalid lanes.
- Surviving words are packed contiguously into an 8-word output vector.
- A full vector is emitted when 8 words accumulate; on last_input_in the partial vector is flushed.

Parameters:
- DATA_W, 64, width of one lane word.
- LANES, 8, number of lanes; fixed at 8 (logic may assume 8).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- last_input_in  input  1  marks the final input beat of a stream; triggers a flush.
- word_in  input  512  lane i = word_in[64*i+63:64*i]; lane 7 is the MSB word.
- word_in_valid  input  8  bit i qualifies lane i.
- word_out  output  512  packed output words, same lane mapping as word_in.
- valid_out  output  8  bit i qualifies word_out lane i; nonzero only on emit cycles.

Behaviour:
- Reset (rst=0, async): buffer contents, fill count (0..7), flush-pending flag, word_out and valid_out all cleared to 0.
- Order and packing:
  - Input order is lane 7 first, down to lane 0.
  - Valid words are compacted in that order. Example: mask 11110000 yields words from lanes 7,6,5,4 in sequence.
  - The buffer fills from lane 7 downward. The first word stored goes to lane 7, the next to lane 6, and so on.
- Each cycle with n = popcount(word_in_valid) and buffer fill f:
  - f+n < 8, no last: append words; f += n; valid_out = 0.
  - f+n >= 8: emit the 8 oldest words on the next clock edge with valid_out = 8'hFF. The remaining f+n-8 words are repacked from lane 7 and become the new fill.
  - last_input_in=1 and f+n <= 8: emit all f+n words top-aligned. valid_out has the top f+n bits set; unused word_out lanes are 0. Buffer is cleared.
  - last_input_in=1 and f+n > 8: emit 8 words (valid_out = FF) and set flush-pending. The next cycle emits the remainder top-aligned, then the buffer clears.
  - last_input_in=1 with n=0 and f=0: nothing emitted.
- Inputs on the cycle while flush-pending is serviced are ignored. Upstream must hold word_in_valid=0 for one cycle after a last beat that overflows.
- Latency: outputs are registered; data appears one clock after the input beat that completes or flushes a vector.
- valid_out returns to 0 the cycle after an emit unless another emit occurs.
- word_out holds 0 in all lanes whenever valid_out = 0.
- No backpressure: the downstream consumer must accept every emitted vector.
- Reset mid-stream discards buffered words with no output.

Optional Feature:
- Macro UBUFF_OCC_EN.
- Defined: adds output port occ_out [3:0], the registered current fill count (0..7), updated the same cycle as the buffer.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> word_out = 0, valid_out = 0; release with no inputs -> outputs stay 0.
- Partial flush stream:
  - Stimulus: beat1 mask 11110000 with lanes 7..4 = 0000000100000002, 0000000300000004, 0000000500000006, 0000000700000008. Beat2 mask 10000000, lane7 = 0000000A0000000B. Beat3 mask 10000000, lane7 = 0000000100000002, last=1.
  - Response: one cycle after beat3, valid_out = 11111100. word_out lanes 7..2 = 0102, 0304, 0506, 0708, 0A0B, 0102 (64-bit values as above); lanes 1..0 = 0.
- Full vector: two beats of mask 11110000 -> valid_out = FF after beat2, all 8 words in arrival order; fill returns to 0.
- Overflow: f=5, then a beat with mask FF and no last -> emit 8 words (5 old + lanes 7..5); remaining 5 words (lanes 4..0) are kept and packed into lanes 7..3.
- Overflowing last: f=3, then mask FF with last=1 -> FF vector, then the next cycle valid_out = 11100000 with the remaining 3 words; then idle.
- Sparse masks: 00000001, 10000001, 00100100 over three beats -> compaction order lane0; lane7, lane0; lane5, lane2. Flush with last shows these 5 words top-aligned.
